// File: rtl/i2c_regf_pkg.sv
// Shared types and constants for the I2C register file.
package i2c_regf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPtr,
    StWdat,
    StRdat
  } state_e;

  localparam int unsigned SYNC_STAGES = 2;
  // R/W flag position inside the I2C address byte
  localparam int unsigned RW_BIT      = 0;

endpackage

// File: rtl/i2c_strobe_sync.sv
// Brings an SCL-domain strobe into clk and emits a one-clk pulse on its rising edge.
module i2c_strobe_sync
  import i2c_regf_pkg::*;
(
  input  logic clk,
  input  logic rst_in,
  input  logic i_strobe,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/i2c_regfile.sv
// Register bank behind an I2C slave: pointer byte then auto-incrementing data, plus host port.
// Optional interrupt output is enabled with the I2C_REGF_IRQ_EN macro.
module i2c_regfile
  import i2c_regf_pkg::*;
#(
  parameter int unsigned         N_REGS  = 16,
  parameter int unsigned         AW      = 4,
  parameter logic [N_REGS-1:0]   RO_MASK = '0,
  parameter logic [7:0]          RST_VAL = 8'h00
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          i2c_as,
  input  logic          i2c_ws,
  input  logic          i2c_rs,
  input  logic [7:0]    i2c_dat,
  output logic [7:0]    i2c_tx,
  input  logic [AW-1:0] host_addr,
  input  logic          host_we,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_stb,
  output logic [AW-1:0] wr_idx
`ifdef I2C_REGF_IRQ_EN
  ,
  output logic          irq,
  input  logic          irq_ack
`endif
);

  logic w_ev_as, w_ev_ws, w_ev_rs;

  i2c_strobe_sync u_sync_as (.clk(clk), .rst_in(rst_in), .i_strobe(i2c_as), .o_pulse(w_ev_as));
  i2c_strobe_sync u_sync_ws (.clk(clk), .rst_in(rst_in), .i_strobe(i2c_ws), .o_pulse(w_ev_ws));
  i2c_strobe_sync u_sync_rs (.clk(clk), .rst_in(rst_in), .i_strobe(i2c_rs), .o_pulse(w_ev_rs));

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_ptr, w_ptr_nxt;
  logic            w_i2c_we;
  logic [7:0]      r_regs [N_REGS];
  logic [7:0]      r_tx;
  logic            r_wr_stb;
  logic [AW-1:0]   r_wr_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_i2c_we    = 1'b0;
    if (w_ev_as) begin
      // A (re)start always takes priority over data strobes
      w_state_nxt = i2c_dat[RW_BIT] ? StRdat : StPtr;
    end else begin
      unique case (r_state)
        StPtr: begin
          if (w_ev_ws) begin
            w_ptr_nxt   = i2c_dat[AW-1:0];
            w_state_nxt = StWdat;
          end
        end
        StWdat: begin
          if (w_ev_ws) begin
            w_i2c_we  = ~RO_MASK[r_ptr];
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
        StRdat: begin
          if (w_ev_rs) w_ptr_nxt = r_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_tx     <= RST_VAL;
      r_wr_stb <= 1'b0;
      r_wr_idx <= '0;
      for (int unsigned i = 0; i < N_REGS; i++) r_regs[i] <= RST_VAL;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_tx     <= r_regs[r_ptr];
      r_wr_stb <= w_i2c_we;
      if (w_i2c_we) r_wr_idx <= r_ptr;
      // I2C write is placed last so it wins a same-index collision with the host
      if (host_we)  r_regs[host_addr] <= host_wdata;
      if (w_i2c_we) r_regs[r_ptr]     <= i2c_dat;
    end
  end

  assign i2c_tx     = r_tx;
  assign wr_stb     = r_wr_stb;
  assign wr_idx     = r_wr_idx;
  assign host_rdata = r_regs[host_addr];

`ifdef I2C_REGF_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in)        r_irq <= 1'b0;
    else if (r_wr_stb) r_irq <= 1'b1;
    else if (irq_ack)  r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_i2c_regfile.sv
// Randomised and directed bench for i2c_regfile against a transaction-level register model.
module tb_i2c_regfile;

  localparam logic [15:0] RO = 16'h0002;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       i2c_as = 1'b0, i2c_ws = 1'b0, i2c_rs = 1'b0;
  logic [7:0] i2c_dat = 8'h00;
  logic [7:0] i2c_tx;
  logic [3:0] host_addr = 4'h0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [3:0] wr_idx;
`ifdef I2C_REGF_IRQ_EN
  logic       irq;
  logic       irq_ack = 1'b0;
`endif

  i2c_regfile #(
    .N_REGS (16),
    .AW     (4),
    .RO_MASK(RO),
    .RST_VAL(8'h00)
  ) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .i2c_as    (i2c_as),
    .i2c_ws    (i2c_ws),
    .i2c_rs    (i2c_rs),
    .i2c_dat   (i2c_dat),
    .i2c_tx    (i2c_tx),
    .host_addr (host_addr),
    .host_we   (host_we),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .wr_stb    (wr_stb),
    .wr_idx    (wr_idx)
`ifdef I2C_REGF_IRQ_EN
    ,
    .irq       (irq),
    .irq_ack   (irq_ack)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: register contents, pointer and which byte the master is sending next
  logic [7:0] m_regs [16];
  int         m_ptr;
  int         m_mode;  // 0 no transaction, 1 awaiting pointer, 2 writing data, 3 reading
  int         exp_stb;
  int         exp_idx;
  int         n_stb = 0;

  always @(negedge clk) if (!rst_in && wr_stb) n_stb++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr   = 0;
    m_mode  = 0;
    exp_idx = 0;
  endtask

  task automatic model_strobe(input int which, input logic [7:0] d);
    if (which == 0) begin
      m_mode = d[0] ? 3 : 1;
    end else if (which == 1) begin
      if (m_mode == 1) begin
        m_ptr  = d % 16;
        m_mode = 2;
      end else if (m_mode == 2) begin
        if (!RO[m_ptr]) begin
          m_regs[m_ptr] = d;
          exp_stb++;
          exp_idx = m_ptr;
        end
        m_ptr = (m_ptr + 1) % 16;
      end
    end else if (which == 2 && m_mode == 3) begin
      m_ptr = (m_ptr + 1) % 16;
    end
  endtask

  task automatic post_checks(input string tag);
    check({tag, ".tx"}, i2c_tx, m_regs[m_ptr]);
    check({tag, ".nstb"}, n_stb, exp_stb);
    check({tag, ".widx"}, wr_idx, exp_idx);
  endtask

  task automatic set_strobe(input int which, input logic v);
    if (which == 0) i2c_as = v;
    else if (which == 1) i2c_ws = v;
    else i2c_rs = v;
  endtask

  // SCL-rate strobe: 8 clk high, 8 clk low, data held throughout
  task automatic strobe(input int which, input logic [7:0] d, input string tag);
    @(negedge clk);
    i2c_dat = d;
    set_strobe(which, 1'b1);
    repeat (8) @(negedge clk);
    set_strobe(which, 1'b0);
    repeat (8) @(negedge clk);
    model_strobe(which, d);
    post_checks(tag);
  endtask

  // Data strobe with a host write to the same index overlapping the synchroniser window
  task automatic strobe_collide(input logic [7:0] d, input logic [3:0] a, input logic [7:0] hd);
    @(negedge clk);
    i2c_dat = d;
    i2c_ws  = 1'b1;
    @(negedge clk);
    host_addr  = a;
    host_wdata = hd;
    host_we    = 1'b1;
    repeat (2) @(negedge clk);
    host_we = 1'b0;
    repeat (5) @(negedge clk);
    i2c_ws = 1'b0;
    repeat (8) @(negedge clk);
    m_regs[a] = hd;
    model_strobe(1, d);
    post_checks("collide");
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we   = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      host_addr = 4'(i);
      #1;
      check($sformatf("%s.reg%0d", tag, i), host_rdata, m_regs[i]);
    end
  endtask

  initial begin
    model_reset();
    exp_stb = 0;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.tx", i2c_tx, 8'h00);
    check("rst.wr_stb", wr_stb, 1'b0);
    check("rst.wr_idx", wr_idx, 4'h0);
    check_all_regs("rst");

    // Master write: pointer 3, two data bytes
    strobe(0, 8'h76, "w.as");
    strobe(1, 8'h03, "w.ptr");
    strobe(1, 8'hA5, "w.d0");
    check("w.idx3", wr_idx, 4'h3);
    strobe(1, 8'h5A, "w.d1");
    check("w.idx4", wr_idx, 4'h4);
    check("w.ptr5", m_ptr, 5);

    // Repeated-start read across the wrap
    host_write(4'hE, 8'hE1);
    host_write(4'hF, 8'hF2);
    host_write(4'h0, 8'h0A);
    host_write(4'h1, 8'h1B);
    strobe(0, 8'h76, "r.as");
    strobe(1, 8'h0E, "r.ptr");
    strobe(0, 8'h77, "r.restart");
    check("r.tx14", i2c_tx, 8'hE1);
    strobe(2, 8'h00, "r.b0");
    check("r.tx15", i2c_tx, 8'hF2);
    strobe(2, 8'h00, "r.b1");
    check("r.tx0", i2c_tx, 8'h0A);
    strobe(2, 8'h00, "r.b2");
    check("r.tx1", i2c_tx, 8'h1B);
    strobe(1, 8'hCC, "r.ws_ignored");

    // Read-only register 1
    strobe(0, 8'h76, "ro.as");
    strobe(1, 8'h01, "ro.ptr");
    strobe(1, 8'hFF, "ro.d0");
    strobe(1, 8'h11, "ro.d1");
    check("ro.reg1", m_regs[1], 8'h1B);
    check_all_regs("ro");

    // Host/I2C collision on index 4
    strobe(0, 8'h76, "col.as");
    strobe(1, 8'h04, "col.ptr");
    strobe_collide(8'h44, 4'h4, 8'h33);
    check_all_regs("col");

    // Reset between pointer and data
    strobe(0, 8'h76, "rm.as");
    strobe(1, 8'h02, "rm.ptr");
    @(negedge clk);
    rst_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    model_reset();
    strobe(1, 8'h99, "rm.ws");
    check_all_regs("rm");
    host_write(4'h0, 8'h5C);
    repeat (2) @(negedge clk);
    check("rm.ptr0", i2c_tx, 8'h5C);

`ifdef I2C_REGF_IRQ_EN
    check("irq.rst", irq, 1'b0);
    strobe(0, 8'h76, "irq.as");
    strobe(1, 8'h07, "irq.ptr");
    strobe(1, 8'h21, "irq.wr");
    check("irq.set", irq, 1'b1);
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    @(negedge clk);
    check("irq.ack", irq, 1'b0);
    @(negedge clk);
    i2c_dat = 8'h22;
    i2c_ws  = 1'b1;
    @(negedge clk);
    irq_ack = 1'b1;
    repeat (3) @(negedge clk);
    irq_ack = 1'b0;
    repeat (4) @(negedge clk);
    i2c_ws = 1'b0;
    repeat (8) @(negedge clk);
    model_strobe(1, 8'h22);
    check("irq.setwins", irq, 1'b1);
    post_checks("irq.coinc");
`endif

    // Random protocol traffic mixed with host writes
    for (int k = 0; k < 150; k++) begin
      int unsigned op;
      logic [7:0]  d;
      op = $urandom_range(0, 5);
      d  = 8'($urandom);
      case (op)
        0: strobe(0, {d[7:1], 1'b0}, "rnd.asw");
        1: strobe(0, {d[7:1], 1'b1}, "rnd.asr");
        2, 3: strobe(1, d, "rnd.ws");
        4: strobe(2, d, "rnd.rs");
        default: host_write(4'($urandom_range(0, 15)), d);
      endcase
    end
    check_all_regs("final");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
